// File: rtl/riscv_pkg.sv
// Shared decode constants and the buffered entry type for the immediate generator.
package riscv_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_Z    = 3'b101;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // imm is always carried sign-extended to 64 bits; the top truncates to XLEN.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational format selection and immediate extension.
// Optional CSR zimm format is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_comb
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic [31:0] instr_i,
  input  logic [2:0]  immsrc_i,
  output imm_entry_t  entry_o
);

`ifdef IMM_GEN_ZIMM_EN
  localparam bit ZIMM_EN = 1'b1;
`else
  localparam bit ZIMM_EN = 1'b0;
`endif

  logic [2:0]  fmt;
  logic        illegal;
  logic [63:0] imm;
  logic        s;

  assign s = instr_i[31];

  always_comb begin
    fmt     = IMM_NONE;
    illegal = 1'b0;
    if (AUTO_DECODE) begin
      case (instr_i[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: fmt = IMM_I;
        OPC_OP_IMM_32: begin
          if (XLEN == 64) fmt = IMM_I;
          else            illegal = 1'b1;
        end
        OPC_STORE:           fmt = IMM_S;
        OPC_BRANCH:          fmt = IMM_B;
        OPC_JAL:             fmt = IMM_J;
        OPC_LUI, OPC_AUIPC:  fmt = IMM_U;
        OPC_OP:              fmt = IMM_NONE;
        OPC_OP_32:           illegal = (XLEN != 64);
        OPC_SYSTEM:          fmt = (instr_i[14] && ZIMM_EN) ? IMM_Z : IMM_NONE;
        default:             illegal = 1'b1;
      endcase
    end else begin
      fmt = immsrc_i;
      // Unsupported explicit codes collapse onto NONE so out_fmt reports what was applied.
      if (fmt == 3'b110 || (fmt == IMM_Z && !ZIMM_EN)) fmt = IMM_NONE;
      illegal = (instr_i[1:0] != 2'b11);
    end
  end

  always_comb begin
    case (fmt)
      IMM_I:   imm = {{52{s}}, instr_i[31:20]};
      IMM_S:   imm = {{52{s}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm = {{52{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:   imm = {{44{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:   imm = {{32{s}}, instr_i[31:12], 12'b0};
      IMM_Z:   imm = {59'b0, instr_i[19:15]};
      default: imm = 64'b0;
    endcase
  end

  assign entry_o = '{instr: instr_i, imm: imm, fmt: fmt, illegal: illegal};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and flush.
// Optional CSR zimm format: define IMM_GEN_ZIMM_EN (handled in imm_gen_comb).
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam imm_entry_t ENTRY_RST = '{instr: '0, imm: '0, fmt: IMM_NONE, illegal: 1'b0};

  imm_entry_t new_entry;
  imm_entry_t main_q, main_d, skid_q, skid_d;
  logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic       accept, drain;
  logic       unused_imm_hi;

  imm_gen_comb #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_comb (
    .instr_i  (in_instr),
    .immsrc_i (in_immsrc),
    .entry_o  (new_entry)
  );

  assign accept = in_valid & ~skid_vld_q;
  assign drain  = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      // Main frees up: the older skid entry goes first; skid full means no accept.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = new_entry;
      end
    end else if (accept) begin
      skid_d     = new_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready      = ~skid_vld_q;
  assign out_valid     = main_vld_q;
  assign out_instr     = main_q.instr;
  assign out_imm       = main_q.imm[XLEN-1:0];
  assign out_fmt       = main_q.fmt;
  assign out_illegal   = main_q.illegal;
  assign unused_imm_hi = ^main_q.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: three DUT flavours (RV32 auto, RV64 auto, RV32 explicit) share one stream.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ZIMM_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0] in_immsrc = '0;
  logic out_ready = 1'b0;

  logic a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_instr, a_out_imm;
  logic [2:0] a_out_fmt;
  logic b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_instr;
  logic [63:0] b_out_imm;
  logic [2:0] b_out_fmt;
  logic c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_instr, c_out_imm;
  logic [2:0] c_out_fmt;

  exp_t qa[$], qb[$], qc[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_instr(c_out_instr), .out_imm(c_out_imm), .out_fmt(c_out_fmt), .out_illegal(c_out_illegal));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: format from the opcode tables, value from signed field arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                 input int xlen, input bit auto_d);
    exp_t e;
    logic [2:0] f;
    bit ill;
    longint v;
    ill = 1'b0;
    if (auto_d) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F: f = 3'd0;
        7'h1B: begin f = (xlen == 64) ? 3'd0 : 3'd7; ill = (xlen != 64); end
        7'h23: f = 3'd1;
        7'h63: f = 3'd2;
        7'h6F: f = 3'd3;
        7'h37, 7'h17: f = 3'd4;
        7'h33: f = 3'd7;
        7'h3B: begin f = 3'd7; ill = (xlen != 64); end
        7'h73: f = (ins[14] && ZEN) ? 3'd5 : 3'd7;
        default: begin f = 3'd7; ill = 1'b1; end
      endcase
    end else begin
      f = src;
      if (f == 3'd6 || (f == 3'd5 && !ZEN)) f = 3'd7;
      ill = (ins[1:0] != 2'b11);
    end
    case (f)
      3'd0: v = longint'($signed(ins[31:20]));
      3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd4: v = longint'($signed(ins[31:12])) * 4096;
      3'd5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    e.instr = ins;
    e.imm = v;
    e.fmt = f;
    e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [14] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h73, 7'h7F};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], opcs[$urandom_range(0, 13)]};
  endfunction

  // One cycle of stimulus, issued 2 time units after a rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                      input logic ordy, input logic fl);
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("b_in_ready", b_in_ready, qb.size() < 2);
    chk("c_in_ready", c_in_ready, qc.size() < 2);
    chk("a_out_valid", a_out_valid, qa.size() > 0);
    in_valid = v; in_instr = ins; in_immsrc = src; out_ready = ordy; flush = fl;
    if (v && (qa.size() < 2) && !fl && !rst) begin
      qa.push_back(model(ins, src, 32, 1'b1));
      qb.push_back(model(ins, src, 64, 1'b1));
      qc.push_back(model(ins, src, 32, 1'b0));
    end
    @(posedge clk); #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_extra", a_out_valid, 1'b0);
      else begin
        e = qa[0];
        chk("a_instr", a_out_instr, e.instr);
        chk("a_imm", a_out_imm, e.imm[31:0]);
        chk("a_fmt", a_out_fmt, e.fmt);
        chk("a_ill", a_out_illegal, e.ill);
        if (out_ready) e = qa.pop_front();
      end
    end
    if (rst || flush) qa.delete();
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_extra", b_out_valid, 1'b0);
      else begin
        e = qb[0];
        chk("b_instr", b_out_instr, e.instr);
        chk("b_imm", b_out_imm, e.imm);
        chk("b_fmt", b_out_fmt, e.fmt);
        chk("b_ill", b_out_illegal, e.ill);
        if (out_ready) e = qb.pop_front();
      end
    end
    if (rst || flush) qb.delete();
  end

  always @(negedge clk) begin
    exp_t e;
    if (c_out_valid === 1'b1) begin
      if (qc.size() == 0) chk("c_extra", c_out_valid, 1'b0);
      else begin
        e = qc[0];
        chk("c_instr", c_out_instr, e.instr);
        chk("c_imm", c_out_imm, e.imm[31:0]);
        chk("c_fmt", c_out_fmt, e.fmt);
        chk("c_ill", c_out_illegal, e.ill);
        if (out_ready) e = qc.pop_front();
      end
    end
    if (rst || flush) qc.delete();
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_ready", a_in_ready, 1'b1);
    chk("rst_a_imm", a_out_imm, 32'h0);
    chk("rst_a_instr", a_out_instr, 32'h0);
    chk("rst_a_fmt", a_out_fmt, 3'b111);
    chk("rst_a_ill", a_out_illegal, 1'b0);
    chk("rst_b_imm", b_out_imm, 64'h0);
    chk("rst_c_fmt", c_out_fmt, 3'b111);
    rst = 1'b0;

    step(1, 32'hFFF00093, 3'd0, 1, 0);
    chk("addi_valid", a_out_valid, 1'b1);
    chk("addi_imm", a_out_imm, 32'hFFFFFFFF);
    chk("addi_fmt", a_out_fmt, 3'b000);
    chk("addi_ill", a_out_illegal, 1'b0);
    step(1, 32'hFE20AE23, 3'd1, 1, 0);
    chk("sw_imm", a_out_imm, 32'hFFFFFFFC);
    chk("sw_fmt", a_out_fmt, 3'b001);
    step(1, 32'h123450B7, 3'd4, 1, 0);
    chk("lui_imm", a_out_imm, 32'h12345000);
    chk("lui_fmt", a_out_fmt, 3'b100);
    step(1, 32'h800000B7, 3'd4, 1, 0);
    chk("lui64_imm", b_out_imm, 64'hFFFFFFFF80000000);
    step(1, 32'h0000007F, 3'd0, 1, 0);
    chk("bad_ill", b_out_illegal, 1'b1);
    chk("bad_imm", b_out_imm, 64'h0);
    step(1, 32'h3401D073, 3'd5, 1, 0);
    chk("csrwi_imm", a_out_imm, ZEN ? 32'd3 : 32'd0);
    chk("csrwi_fmt", a_out_fmt, ZEN ? 3'b101 : 3'b111);
    chk("csrwi_c_fmt", c_out_fmt, ZEN ? 3'b101 : 3'b111);
    step(0, 32'h0, 3'd0, 1, 0);
    step(0, 32'h0, 3'd0, 1, 0);

    // Stall downstream while streaming; then release.
    step(1, 32'h00100113, 3'd0, 0, 0);
    chk("stall1_ready", a_in_ready, 1'b1);
    step(1, 32'h00200193, 3'd0, 0, 0);
    chk("stall2_ready", a_in_ready, 1'b0);
    step(1, 32'h00300213, 3'd0, 0, 0);
    chk("stall3_ready", a_in_ready, 1'b0);
    chk("stall3_instr", a_out_instr, 32'h00100113);
    step(0, 32'h0, 3'd0, 1, 0);
    chk("rel1_instr", a_out_instr, 32'h00200193);
    step(0, 32'h0, 3'd0, 1, 0);
    chk("rel2_valid", a_out_valid, 1'b0);

    // Flush with two entries buffered and a concurrent input.
    step(1, 32'h00500293, 3'd0, 0, 0);
    step(1, 32'h00600313, 3'd0, 0, 0);
    step(1, 32'h00700393, 3'd0, 0, 1);
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ready", a_in_ready, 1'b1);
    step(0, 32'h0, 3'd0, 1, 0);
    step(0, 32'h0, 3'd0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, rand_instr(), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    repeat (4) step(0, 32'h0, 3'd0, 1, 0);
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    chk("end_qc_empty", qc.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
